// File: rtl/conv_2.sv
// ---------------------------------------------------------------------------
// conv_2 : second convolution stage.
//
// Reads the IN_CH x IN_DIM x IN_DIM feature map produced by pooling_1 and
// computes OUT_CH output maps of OUT_DIM x OUT_DIM using a KxK kernel with
// stride 1 and no padding. Each output pixel is bias + sum of IN_CH*K*K
// products, scaled back to Q16.16, saturated to 32 bits and passed through
// ReLU before being written to the next buffer. One multiply-accumulate is
// issued per clock. All memories are external with a 1-cycle read latency.
//
// Ports
//   Clk          clock
//   Reset        synchronous, active-high reset (aborts a run immediately)
//   start        begin a layer; only looked at while idle
//   data_addr    input map address  = ic*IN_DIM^2 + (oy+ky)*IN_DIM + (ox+kx)
//   curdata      input map word, valid one cycle after data_addr
//   weight_addr  weight ROM address = oc*TAPS + t, t = ic*K*K + ky*K + kx
//   weight_data  weight word, valid one cycle after weight_addr
//   bias_addr    bias ROM address   = oc
//   bias_data    bias word, valid one cycle after bias_addr
//   out_addr     result address     = oc*OUT_DIM^2 + oy*OUT_DIM + ox
//   out_data     ReLU'd, saturated result (meaningful while out_wren = 1)
//   out_wren     result write strobe
//   ready        one-cycle pulse when the whole layer has been written
//
// Per output pixel: BIAS (1) + MAC (TAPS) + DRAIN (1) + SAVE (1) cycles.
// ---------------------------------------------------------------------------
module conv_2 #(
   parameter int IN_CH  = 6,
   parameter int IN_DIM = 14,
   parameter int K      = 5,
   parameter int OUT_CH = 16,
   parameter int FRAC   = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   output logic [13:0] data_addr,
   input  logic [31:0] curdata,
   output logic [11:0] weight_addr,
   input  logic [31:0] weight_data,
   output logic [3:0]  bias_addr,
   input  logic [31:0] bias_data,
   output logic [10:0] out_addr,
   output logic [31:0] out_data,
   output logic        out_wren,
   output logic        ready
);

   localparam int OUT_DIM = IN_DIM - K + 1;
   localparam int TAPS    = IN_CH * K * K;
   localparam int MAP_SZ  = IN_DIM * IN_DIM;
   localparam int OUT_SZ  = OUT_DIM * OUT_DIM;

   localparam logic [15:0] TAPS_LAST = 16'(TAPS - 1);
   localparam logic [15:0] K_LAST    = 16'(K - 1);
   localparam logic [15:0] DIM_LAST  = 16'(OUT_DIM - 1);
   localparam logic [15:0] OC_LAST   = 16'(OUT_CH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_MAC,
      S_DRAIN,
      S_SAVE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // Tap position (t and its decomposition ic/ky/kx kept in step so no
   // division is needed) and output pixel position.
   logic [15:0] t_q,  t_d;
   logic [15:0] ic_q, ic_d;
   logic [15:0] ky_q, ky_d;
   logic [15:0] kx_q, kx_d;
   logic [15:0] ox_q, ox_d;
   logic [15:0] oy_q, oy_d;
   logic [15:0] oc_q, oc_d;

   logic signed [71:0] acc_q, acc_d;

   logic signed [63:0] product_w;
   logic signed [71:0] product_ext_w;
   logic signed [71:0] bias_ext_w;
   logic signed [71:0] bias_init_w;
   logic signed [71:0] shifted_w;

   // ------------------------------------------------------------------
   // Addresses are pure functions of the counters, so after reset (all
   // counters zero) every address output is zero.
   // ------------------------------------------------------------------
   assign data_addr   = 14'(ic_q * 16'(MAP_SZ) + (oy_q + ky_q) * 16'(IN_DIM)
                            + ox_q + kx_q);
   assign weight_addr = 12'(oc_q * 16'(TAPS) + t_q);
   assign bias_addr   = 4'(oc_q);
   assign out_addr    = 11'(oc_q * 16'(OUT_SZ) + oy_q * 16'(OUT_DIM) + ox_q);

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   assign product_w     = $signed(curdata) * $signed(weight_data);
   assign product_ext_w = {{8{product_w[63]}}, product_w};
   assign bias_ext_w    = {{40{bias_data[31]}}, bias_data};
   // Bias is Q16.16; products are Q32.32, so the bias is lifted to match.
   assign bias_init_w   = bias_ext_w <<< FRAC;
   assign shifted_w     = acc_q >>> FRAC;

   // Saturate to signed 32 bits, then ReLU. Because ReLU discards every
   // negative value, the lower clamp never reaches the output.
   always_comb begin
      out_data = shifted_w[31:0];
      if (shifted_w[71]) begin
         out_data = 32'h0000_0000;
      end else if (|shifted_w[70:31]) begin
         out_data = 32'h7FFF_FFFF;
      end
   end

   // ------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         ic_q    <= '0;
         ky_q    <= '0;
         kx_q    <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         oc_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         ic_q    <= ic_d;
         ky_q    <= ky_d;
         kx_q    <= kx_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         oc_q    <= oc_d;
         acc_q   <= acc_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, counter and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      ic_d     = ic_q;
      ky_d     = ky_q;
      kx_d     = kx_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      oc_d     = oc_q;
      acc_d    = acc_q;
      out_wren = 1'b0;
      ready    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_BIAS;
               t_d     = '0;
               ic_d    = '0;
               ky_d    = '0;
               kx_d    = '0;
               ox_d    = '0;
               oy_d    = '0;
               oc_d    = '0;
            end
         end

         S_BIAS: begin
            // bias_addr already shows oc; its word arrives during MAC t=0.
            t_d     = '0;
            ic_d    = '0;
            ky_d    = '0;
            kx_d    = '0;
            state_d = S_MAC;
         end

         S_MAC: begin
            // The operands visible now belong to the tap issued last cycle,
            // so t=0 loads the bias instead of accumulating.
            if (t_q == 16'd0) begin
               acc_d = bias_init_w;
            end else begin
               acc_d = acc_q + product_ext_w;
            end

            if (t_q == TAPS_LAST) begin
               state_d = S_DRAIN;
            end else begin
               t_d = t_q + 16'd1;
               if (kx_q == K_LAST) begin
                  kx_d = '0;
                  if (ky_q == K_LAST) begin
                     ky_d = '0;
                     ic_d = ic_q + 16'd1;
                  end else begin
                     ky_d = ky_q + 16'd1;
                  end
               end else begin
                  kx_d = kx_q + 16'd1;
               end
            end
         end

         S_DRAIN: begin
            // Collect the product of the final tap.
            acc_d   = acc_q + product_ext_w;
            state_d = S_SAVE;
         end

         S_SAVE: begin
            out_wren = 1'b1;
            state_d  = S_BIAS;
            if (ox_q == DIM_LAST) begin
               ox_d = '0;
               if (oy_q == DIM_LAST) begin
                  oy_d = '0;
                  if (oc_q == OC_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     oc_d = oc_q + 16'd1;
                  end
               end else begin
                  oy_d = oy_q + 16'd1;
               end
            end else begin
               ox_d = ox_q + 16'd1;
            end
         end

         S_DONE: begin
            ready   = 1'b1;
            t_d     = '0;
            ic_d    = '0;
            ky_d    = '0;
            kx_d    = '0;
            ox_d    = '0;
            oy_d    = '0;
            oc_d    = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_2.sv
// ---------------------------------------------------------------------------
// tb_conv_2 : self-checking bench for conv_2.
//
// The layer is instantiated with reduced dimensions (3 input channels of
// 6x6, 3x3 kernel, 6 output channels of 4x4) so that each run takes
// 1 + 96*30 = 2881 cycles. Memories are modelled with a registered read.
// Expected writes are pushed to a scoreboard when a run is set up and popped
// by a monitor as the design writes them.
// ---------------------------------------------------------------------------
module tb_conv_2;

   localparam int IN_CH   = 3;
   localparam int IN_DIM  = 6;
   localparam int K       = 3;
   localparam int OUT_CH  = 6;
   localparam int FRAC    = 16;
   localparam int OUT_DIM = IN_DIM - K + 1;
   localparam int TAPS    = IN_CH * K * K;
   localparam int MAP_SZ  = IN_DIM * IN_DIM;
   localparam int OUT_SZ  = OUT_DIM * OUT_DIM;
   localparam int NPIX    = OUT_CH * OUT_SZ;
   localparam int RUN_CYC = 1 + NPIX * (TAPS + 3);

   logic        clk;
   logic        Reset;
   logic        start;
   logic [13:0] data_addr;
   logic [31:0] curdata;
   logic [11:0] weight_addr;
   logic [31:0] weight_data;
   logic [3:0]  bias_addr;
   logic [31:0] bias_data;
   logic [10:0] out_addr;
   logic [31:0] out_data;
   logic        out_wren;
   logic        ready;

   logic [31:0] dmem [0:16383];
   logic [31:0] wmem [0:4095];
   logic [31:0] bmem [0:15];

   logic [10:0] exp_addr_q [$];
   logic [31:0] exp_data_q [$];
   logic [10:0] mon_ea;
   logic [31:0] mon_ed;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int wr_cnt    = 0;
   int ready_cnt = 0;
   int ready_cyc = 0;
   int start_cyc = 0;

   conv_2 #(
      .IN_CH  (IN_CH),
      .IN_DIM (IN_DIM),
      .K      (K),
      .OUT_CH (OUT_CH),
      .FRAC   (FRAC)
   ) dut (
      .Clk         (clk),
      .Reset       (Reset),
      .start       (start),
      .data_addr   (data_addr),
      .curdata     (curdata),
      .weight_addr (weight_addr),
      .weight_data (weight_data),
      .bias_addr   (bias_addr),
      .bias_data   (bias_data),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .out_wren    (out_wren),
      .ready       (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // External memories, 1-cycle read latency.
   always @(posedge clk) begin
      curdata     <= dmem[data_addr];
      weight_data <= wmem[weight_addr];
      bias_data   <= bmem[bias_addr];
   end

   // Monitor: every write is compared against the head of the scoreboard.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         ready_cnt = ready_cnt + 1;
         ready_cyc = cyc;
      end
      if (out_wren === 1'b1) begin
         wr_cnt = wr_cnt + 1;
         checks = checks + 1;
         if (exp_addr_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                     out_addr, out_data);
         end else begin
            mon_ea = exp_addr_q.pop_front();
            mon_ed = exp_data_q.pop_front();
            if (out_addr !== mon_ea || out_data !== mon_ed) begin
               errors = errors + 1;
               $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                        out_addr, out_data, mon_ea, mon_ed);
            end else begin
               $display("write addr %0d data %h ok", out_addr, out_data);
            end
         end
      end
   end

   // Global safety net.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time %0t exceeded, required earlier finish", $time);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Helpers (stimulus and reference model)
   // ------------------------------------------------------------------
   task automatic fill(input logic [31:0] dval, input logic [31:0] wval,
                       input logic [31:0] bval);
      for (int i = 0; i < IN_CH * MAP_SZ; i++) dmem[i] = dval;
      for (int i = 0; i < OUT_CH * TAPS; i++)  wmem[i] = wval;
      for (int i = 0; i < OUT_CH; i++)         bmem[i] = bval;
   endtask

   // Direct convolution of the memory contents for the first n pixels.
   task automatic push_expected(input int n);
      logic signed [31:0] d, w, b;
      logic signed [79:0] acc, sh;
      logic [31:0]        r;
      int oc, oy, ox;
      for (int p = 0; p < n; p++) begin
         oc  = p / OUT_SZ;
         oy  = (p / OUT_DIM) % OUT_DIM;
         ox  = p % OUT_DIM;
         b   = bmem[oc];
         acc = b;
         acc = acc <<< FRAC;
         for (int ic = 0; ic < IN_CH; ic++)
            for (int ky = 0; ky < K; ky++)
               for (int kx = 0; kx < K; kx++) begin
                  d   = dmem[ic * MAP_SZ + (oy + ky) * IN_DIM + ox + kx];
                  w   = wmem[oc * TAPS + ic * K * K + ky * K + kx];
                  acc = acc + d * w;
               end
         sh = acc >>> FRAC;
         if (sh < 0)                     r = 32'h0000_0000;
         else if (sh > 80'sh7FFF_FFFF)   r = 32'h7FFF_FFFF;
         else                            r = sh[31:0];
         exp_addr_q.push_back(11'(p));
         exp_data_q.push_back(r);
      end
   endtask

   task automatic start_run(input bit hold);
      @(posedge clk);
      #1;
      start     = 1'b1;
      start_cyc = cyc;
      wr_cnt    = 0;
      if (!hold) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_ready(input string name);
      int r0;
      bit seen;
      r0   = ready_cnt;
      seen = 1'b0;
      for (int i = 0; i < RUN_CYC + 50; i++) begin
         @(negedge clk);
         #2;
         if (ready_cnt != r0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s_ready_timeout: got no ready in %0d cycles, required ready pulse",
                  name, RUN_CYC + 50);
      end
   endtask

   // Start a run, wait for ready, then verify latency, write count and
   // that the scoreboard was fully consumed.
   task automatic run_full(input string name);
      start_run(1'b0);
      wait_ready(name);
      checks = checks + 1;
      if ((ready_cyc - start_cyc) !== RUN_CYC) begin
         errors = errors + 1;
         $display("FAIL %s_latency: got %0d cycles, required %0d",
                  name, ready_cyc - start_cyc, RUN_CYC);
      end
      checks = checks + 1;
      if (wr_cnt !== NPIX) begin
         errors = errors + 1;
         $display("FAIL %s_writes: got %0d, required %0d", name, wr_cnt, NPIX);
      end
      checks = checks + 1;
      if (exp_addr_q.size() !== 0) begin
         errors = errors + 1;
         $display("FAIL %s_pending: got %0d unwritten results, required 0",
                  name, exp_addr_q.size());
         exp_addr_q.delete();
         exp_data_q.delete();
      end
      $display("run %s: %0d writes, ready after %0d cycles", name, wr_cnt,
               ready_cyc - start_cyc);
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      Reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks = checks + 6;
      if (out_wren !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_out_wren: got %b, required 0", out_wren);
      end
      if (ready !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_ready: got %b, required 0", ready);
      end
      if (data_addr !== 14'd0) begin
         errors = errors + 1;
         $display("FAIL reset_data_addr: got %0d, required 0", data_addr);
      end
      if (weight_addr !== 12'd0) begin
         errors = errors + 1;
         $display("FAIL reset_weight_addr: got %0d, required 0", weight_addr);
      end
      if (bias_addr !== 4'd0) begin
         errors = errors + 1;
         $display("FAIL reset_bias_addr: got %0d, required 0", bias_addr);
      end
      if (out_addr !== 11'd0) begin
         errors = errors + 1;
         $display("FAIL reset_out_addr: got %0d, required 0", out_addr);
      end
      @(posedge clk);
      #1;
      Reset = 1'b0;
      $display("reset checked");
   endtask

   // All-ones data and weights: every result is TAPS * 1.0.
   task automatic test_ones();
      fill(32'h0001_0000, 32'h0001_0000, 32'h0);
      push_expected(NPIX);
      if (exp_data_q[0] !== 32'(TAPS) << 16) begin
         $display("note: reference value %h", exp_data_q[0]);
      end
      run_full("ones");
   endtask

   task automatic test_bias();
      fill(32'h0001_0000, 32'h0, 32'hFFFE_0000);
      push_expected(NPIX);
      run_full("bias_neg");
      fill(32'h0001_0000, 32'h0, 32'h0003_0000);
      push_expected(NPIX);
      run_full("bias_pos");
   endtask

   // One non-zero weight: output is a shifted copy of input channel 2.
   task automatic test_single_tap();
      int oc, oy, ox;
      fill(32'h0, 32'h0, 32'h0);
      for (int i = 0; i < IN_CH * MAP_SZ; i++) dmem[i] = 32'(i) << 16;
      wmem[5 * TAPS + 2 * K * K + 1 * K + 2] = 32'h0001_0000;
      for (int p = 0; p < NPIX; p++) begin
         oc = p / OUT_SZ;
         oy = (p / OUT_DIM) % OUT_DIM;
         ox = p % OUT_DIM;
         exp_addr_q.push_back(11'(p));
         if (oc == 5) exp_data_q.push_back(32'(2 * MAP_SZ + (oy + 1) * IN_DIM + ox + 2) << 16);
         else         exp_data_q.push_back(32'h0);
      end
      run_full("single_tap");
   endtask

   task automatic test_saturate();
      fill(32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
      for (int p = 0; p < NPIX; p++) begin
         exp_addr_q.push_back(11'(p));
         exp_data_q.push_back(32'h7FFF_FFFF);
      end
      run_full("sat_pos");
      fill(32'h8001_0000, 32'h7FFF_0000, 32'h0);
      for (int p = 0; p < NPIX; p++) begin
         exp_addr_q.push_back(11'(p));
         exp_data_q.push_back(32'h0);
      end
      run_full("sat_neg");
   endtask

   task automatic test_reset_abort();
      int r0;
      bit reached;
      fill(32'h0001_0000, 32'h0002_0000, 32'h0000_8000);
      push_expected(37);
      start_run(1'b0);
      reached = 1'b0;
      for (int i = 0; i < 40 * (TAPS + 3); i++) begin
         @(negedge clk);
         #2;
         if (wr_cnt == 37) begin
            reached = 1'b1;
            break;
         end
      end
      checks = checks + 1;
      if (!reached) begin
         errors = errors + 1;
         $display("FAIL abort_reach: got %0d writes, required 37 before reset", wr_cnt);
      end
      // Land the reset a few taps into pixel 37's MAC phase.
      repeat (5) @(posedge clk);
      #1;
      Reset = 1'b1;
      r0    = ready_cnt;
      @(posedge clk);
      @(negedge clk);
      checks = checks + 2;
      if (out_wren !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL abort_wren: got %b, required 0", out_wren);
      end
      if (out_addr !== 11'd0) begin
         errors = errors + 1;
         $display("FAIL abort_out_addr: got %0d, required 0", out_addr);
      end
      #1;
      Reset = 1'b0;
      repeat (2 * (TAPS + 3)) @(negedge clk);
      #2;
      checks = checks + 2;
      if (ready_cnt !== r0) begin
         errors = errors + 1;
         $display("FAIL abort_ready: got %0d pulses, required 0", ready_cnt - r0);
      end
      if (wr_cnt !== 37) begin
         errors = errors + 1;
         $display("FAIL abort_writes: got %0d, required 37", wr_cnt);
      end
      exp_addr_q.delete();
      exp_data_q.delete();
      $display("abort checked after %0d writes", wr_cnt);
      push_expected(NPIX);
      run_full("after_abort");
   endtask

   task automatic test_start_held();
      int r0;
      int v;
      for (int i = 0; i < IN_CH * MAP_SZ; i++) begin
         v = int'($urandom_range(0, 524287)) - 262144;
         dmem[i] = 32'(v);
      end
      for (int i = 0; i < OUT_CH * TAPS; i++) begin
         v = int'($urandom_range(0, 131071)) - 65536;
         wmem[i] = 32'(v);
      end
      for (int i = 0; i < OUT_CH; i++) begin
         v = int'($urandom_range(0, 262143)) - 131072;
         bmem[i] = 32'(v);
      end

      // start held high until ready is seen
      push_expected(NPIX);
      r0 = ready_cnt;
      start_run(1'b1);
      wait_ready("held");
      start = 1'b0;
      checks = checks + 1;
      if ((ready_cyc - start_cyc) !== RUN_CYC) begin
         errors = errors + 1;
         $display("FAIL held_latency: got %0d cycles, required %0d",
                  ready_cyc - start_cyc, RUN_CYC);
      end
      repeat (20) @(negedge clk);
      #2;
      checks = checks + 2;
      if (ready_cnt - r0 !== 1) begin
         errors = errors + 1;
         $display("FAIL held_ready_count: got %0d, required 1", ready_cnt - r0);
      end
      if (wr_cnt !== NPIX) begin
         errors = errors + 1;
         $display("FAIL held_writes: got %0d, required %0d", wr_cnt, NPIX);
      end
      $display("run held: %0d writes", wr_cnt);

      // start pulsed while running must be ignored
      push_expected(NPIX);
      r0 = ready_cnt;
      start_run(1'b0);
      for (int k = 0; k < 3; k++) begin
         repeat (500) @(posedge clk);
         #1;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      wait_ready("pulsed");
      repeat (20) @(negedge clk);
      #2;
      checks = checks + 2;
      if (ready_cnt - r0 !== 1) begin
         errors = errors + 1;
         $display("FAIL pulsed_ready_count: got %0d, required 1", ready_cnt - r0);
      end
      if (wr_cnt !== NPIX) begin
         errors = errors + 1;
         $display("FAIL pulsed_writes: got %0d, required %0d", wr_cnt, NPIX);
      end
      $display("run pulsed: %0d writes", wr_cnt);

      // a fresh start after DONE repeats the same layer
      push_expected(NPIX);
      run_full("rerun");
   endtask

   initial begin
      Reset = 1'b1;
      start = 1'b0;
      test_reset();
      test_ones();
      test_bias();
      test_single_tap();
      test_saturate();
      test_reset_abort();
      test_start_held();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
